// File: rtl/greedy_snake_ctrl_if.sv
// DPB channel A, body-list descriptor and renderer handshake of the snake game-step controller.
interface greedy_snake_ctrl_if;
  logic        a_clk_en;
  logic        a_data_en;
  logic        a_wr_en;
  logic [10:0] a_address;
  logic [7:0]  a_data;
  logic [10:0] list_length;
  logic [10:0] list_head_addr;
  logic        render_en;
  logic        render_busy;
  logic        render_game_over;

  modport master (
    output a_clk_en, a_data_en, a_wr_en, a_address, a_data,
    output list_length, list_head_addr, render_en,
    input  render_busy, render_game_over
  );

  modport slave (
    input  a_clk_en, a_data_en, a_wr_en, a_address, a_data,
    input  list_length, list_head_addr, render_en,
    output render_busy, render_game_over
  );
endinterface

// File: rtl/greedy_snake_ctrl.sv
// Greedy Snake game-step scheduler: moves the head into the BSRAM body ring, then
// runs the body-list renderer and freezes when it reports a collision.
module greedy_snake_ctrl #(
  parameter logic [10:0] ADDRESS_STEP_N     = 11'd4,
  parameter logic [10:0] DATA_BEGIN_ADDRESS = 11'd4,
  parameter logic [10:0] MAX_LEN            = 11'd256,
  parameter logic [10:0] INIT_LEN           = 11'd3,
  parameter logic [3:0]  INIT_Y             = 4'd8,
  parameter logic [3:0]  RENDER_RISE_MAX    = 4'd15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [1:0]           dir,
  input  logic [7:0]           food_pos,
  greedy_snake_ctrl_if.master  bus,
  output logic                 busy,
  output logic                 game_over,
  output logic                 food_eaten
);
  typedef enum logic [2:0] {
    INIT, WAIT_TICK, CALC, WRITE, RENDER_REQ, RENDER_WAIT, CHECK, OVER
  } state_t;

  state_t      state;
  logic [10:0] init_cnt, head_idx, len;
  logic [7:0]  head_pos, grow_pending;
  logic [1:0]  cur_dir;
  logic [3:0]  wait_cnt;
  logic        seen_rise;

  logic [1:0]  n_dir;
  logic [3:0]  nx, ny;
  logic [7:0]  next_pos, gp_next;
  logic [8:0]  gp_sum;
  logic [10:0] new_idx, new_len;
  logic        grow, eat;

  function automatic logic [10:0] slot_addr(input logic [10:0] idx);
    return DATA_BEGIN_ADDRESS + idx * ADDRESS_STEP_N;
  endfunction

  assign bus.a_clk_en  = 1'b1;
  assign bus.a_data_en = 1'b1;

  // Next-move decision, consumed only in CALC. x/y are 4 bits so the grid wraps for free.
  always_comb begin
    n_dir = (dir == (cur_dir ^ 2'd2)) ? cur_dir : dir;
    nx    = head_pos[7:4];
    ny    = head_pos[3:0];
    case (n_dir)
      2'd0:    nx = nx + 4'd1;
      2'd1:    ny = ny + 4'd1;
      2'd2:    nx = nx - 4'd1;
      default: ny = ny - 4'd1;
    endcase
    next_pos = {nx, ny};
    eat      = (next_pos == food_pos);
    grow     = (grow_pending != 8'd0) && (head_idx == len - 11'd1) && (len < MAX_LEN);
    new_len  = grow ? len + 11'd1 : len;
    if (grow)                         new_idx = len;
    else if (head_idx == len - 11'd1) new_idx = 11'd0;
    else                              new_idx = head_idx + 11'd1;
    // grow implies grow_pending > 0, so the sum never underflows; bit 8 means saturate.
    gp_sum  = {1'b0, grow_pending} + {8'd0, eat} - {8'd0, grow};
    gp_next = gp_sum[8] ? 8'hFF : gp_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= INIT;
      init_cnt           <= '0;
      head_idx           <= '0;
      len                <= '0;
      head_pos           <= '0;
      cur_dir            <= '0;
      grow_pending       <= '0;
      wait_cnt           <= '0;
      seen_rise          <= 1'b0;
      bus.a_wr_en        <= 1'b0;
      bus.a_address      <= '0;
      bus.a_data         <= '0;
      bus.list_length    <= '0;
      bus.list_head_addr <= '0;
      bus.render_en      <= 1'b0;
      busy               <= 1'b0;
      game_over          <= 1'b0;
      food_eaten         <= 1'b0;
    end else begin
      bus.a_wr_en   <= 1'b0;
      bus.render_en <= 1'b0;
      food_eaten    <= 1'b0;
      case (state)
        INIT: begin
          busy <= 1'b1;
          if (init_cnt < INIT_LEN) begin
            bus.a_wr_en   <= 1'b1;
            bus.a_address <= slot_addr(init_cnt);
            bus.a_data    <= {init_cnt[3:0], INIT_Y};
            init_cnt      <= init_cnt + 11'd1;
            if (init_cnt == INIT_LEN - 11'd1) begin
              head_idx           <= init_cnt;
              len                <= INIT_LEN;
              head_pos           <= {init_cnt[3:0], INIT_Y};
              cur_dir            <= 2'd0;
              grow_pending       <= 8'd0;
              bus.list_length    <= INIT_LEN;
              bus.list_head_addr <= slot_addr(init_cnt);
            end
          end else if (!bus.render_busy) begin
            bus.render_en <= 1'b1;
            state         <= RENDER_REQ;
          end
        end
        WAIT_TICK: if (tick) begin
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          cur_dir            <= n_dir;
          head_idx           <= new_idx;
          head_pos           <= next_pos;
          len                <= new_len;
          grow_pending       <= gp_next;
          bus.a_wr_en        <= 1'b1;
          bus.a_address      <= slot_addr(new_idx);
          bus.a_data         <= next_pos;
          bus.list_length    <= new_len;
          bus.list_head_addr <= slot_addr(new_idx);
          food_eaten         <= eat;
          state              <= WRITE;
        end
        WRITE: if (!bus.render_busy) begin
          bus.render_en <= 1'b1;
          state         <= RENDER_REQ;
        end
        RENDER_REQ: begin
          wait_cnt  <= '0;
          seen_rise <= 1'b0;
          state     <= RENDER_WAIT;
        end
        RENDER_WAIT: begin
          if (!seen_rise) begin
            if (bus.render_busy) seen_rise <= 1'b1;
            else if (wait_cnt == RENDER_RISE_MAX - 4'd1) begin
              // renderer never answered: pulse it again
              bus.render_en <= 1'b1;
              state         <= RENDER_REQ;
            end else wait_cnt <= wait_cnt + 4'd1;
          end else if (!bus.render_busy) state <= CHECK;
        end
        CHECK: begin
          busy <= 1'b0;
          if (bus.render_game_over) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else state <= WAIT_TICK;
        end
        OVER: if (start) begin
          game_over <= 1'b0;
          busy      <= 1'b1;
          init_cnt  <= '0;
          state     <= INIT;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: doc/greedy_snake_ctrl.md
# greedy_snake_ctrl

Game-step scheduler for the Greedy Snake BSRAM datapath. On each game tick it computes the new head cell, writes it into the snake body list through Gowin_DPB channel A, publishes `list_length`/`list_head_addr`, then triggers the body-list renderer through its `en`/`busy` handshake. After the renderer finishes, it samples the renderer's `game_over_flag` and either continues or freezes. It sits between the tick/keypad/food logic and the DPB, renderer and HDMI path.

## Interface
- `ADDRESS_STEP_N`, 11'd4: address stride between list slots.
- `DATA_BEGIN_ADDRESS`, 11'd4: address of slot 0.
- `MAX_LEN`, 11'd256: maximum number of slots (16x16 grid).
- `INIT_LEN`, 11'd3: initial body length (must be 2..16).
- `INIT_Y`, 4'd8: row of the initial snake.
- `RENDER_RISE_MAX`, 4'd15: cycles to wait for renderer `busy` before re-pulsing.

- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle game-step pulse.
- `start` in 1: one-cycle restart request, honoured only in OVER.
- `dir` in 2: requested direction. 0 = right (x+1), 1 = down (y+1), 2 = left, 3 = up.
- `food_pos` in 8: food cell, {x[7:4], y[3:0]}.
- `a_clk_en`, `a_data_en` out 1: DPB channel A enables.
- `a_wr_en` out 1: DPB channel A write strobe.
- `a_address` out 11: DPB channel A address.
- `a_data` out 8: DPB channel A write data, {x, y}.
- `list_length` out 11: number of valid slots, to the renderer.
- `list_head_addr` out 11: DPB address of the head slot, to the renderer.
- `render_en` out 1: renderer start pulse.
- `render_busy` in 1: renderer `busy`.
- `render_game_over` in 1: renderer `game_over_flag`.
- `busy` out 1: high whenever the controller is not in WAIT_TICK or OVER.
- `game_over` out 1: game-over indication.
- `food_eaten` out 1: one-cycle pulse when the snake eats food.

## Operation
- **Slot address rule.** Address of slot i = `DATA_BEGIN_ADDRESS` + i*`ADDRESS_STEP_N`, computed in 11 bits.
- **Body storage.** Occupied slots are 0..len-1 and form a ring ordered tail to head. The tail slot is (head_idx+1) mod len.
- **Internal registers.** head_idx[10:0], len[10:0], head_pos[7:0], cur_dir[1:0], grow_pending[7:0] (saturates at 255).
- **States:** INIT, WAIT_TICK, CALC, WRITE, RENDER_REQ, RENDER_WAIT, CHECK, OVER.
- **INIT.** Writes `INIT_LEN` slots, one per cycle. Slot k = {k, `INIT_Y`}. Then: head_idx = `INIT_LEN`-1, len = `INIT_LEN`, cur_dir = 0, grow_pending = 0, head_pos = {`INIT_LEN`-1, `INIT_Y`}. Next state is RENDER_REQ.
- **WAIT_TICK.** On `tick`, go to CALC. Ticks arriving in any other state are dropped.
- **CALC, direction.** If `dir` == cur_dir^2 (reversal), keep cur_dir; otherwise cur_dir = `dir`.
- **CALC, next head.** next_pos steps one cell in cur_dir. x and y each wrap modulo 16 (e.g. x 15 + 1 -> 0, y 0 - 1 -> 15).
- **CALC, growth.** Growth applies when grow_pending > 0, head_idx == len-1 and len < `MAX_LEN`. Then new_idx = len, len increments and grow_pending decrements; the tail is kept.
- **CALC, plain move.** Otherwise new_idx = (head_idx == len-1) ? 0 : head_idx+1, which overwrites the tail.
- **CALC, food.** If next_pos == `food_pos`, grow_pending increments. The growth decision above uses the value before this increment, so net change is +inc -dec in the same cycle.
- **WRITE.** Drives `a_address` = slot(new_idx), `a_data` = next_pos, `a_wr_en` = 1 for exactly one cycle. In the same cycle it updates head_idx, head_pos, `list_length` and `list_head_addr`, and pulses `food_eaten` if food was eaten.
- **RENDER_REQ.** Entered only when `render_busy` = 0; otherwise stay. Pulses `render_en` for one cycle, then goes to RENDER_WAIT.
- **RENDER_WAIT.** Waits for `render_busy` to rise, then fall. If no rise within `RENDER_RISE_MAX` cycles, return to RENDER_REQ.
- **CHECK.** If `render_game_over` = 1, go to OVER; else go to WAIT_TICK.
- **OVER.** Holds `game_over` = 1 and ignores `tick`. On `start`, clear `game_over` and go to INIT.
- **Output stability.** `list_length` and `list_head_addr` change only in INIT and WRITE, never while the renderer is busy.

## Timing
- **Reset values:** state INIT, `a_clk_en` 1, `a_data_en` 1, `a_wr_en` 0, `a_address` 0, `a_data` 0, `list_length` 0, `list_head_addr` 0, `render_en` 0, `busy` 0, `game_over` 0, `food_eaten` 0.
- **After reset.** `busy` = 1 from the first cycle after `rst` deasserts. INIT write cycles occupy cycles 1..`INIT_LEN`.
- **Tick to render.** Tick sampled at edge T. CALC is in T+1, `a_wr_en` is high in T+2, `render_en` is high in T+3 (when `render_busy` = 0).
- **Renderer handshake.** `render_busy` is expected high from the cycle after `render_en`. CHECK is the cycle after `render_busy` falls. WAIT_TICK or OVER follows one cycle later.
- **Reset mid-operation.** `rst` in any state, including during a DPB write or render, returns all outputs to reset values next edge and restarts INIT. Stale renderer activity is ignored until the next RENDER_REQ.
- **Simultaneous tick and start.** In OVER, `start` wins; in WAIT_TICK, `start` is ignored.

## Test plan
- **Reset and INIT.** Reset, then idle. Required: writes {0,8}, {1,8}, {2,8} to addresses 4, 8, 12; `list_length` = 3, `list_head_addr` = 12; one `render_en` pulse.
- **Plain move.** One tick with `dir` = 0 and `food_pos` = 8'hFF. Required: write {3,8} to address 4 (the tail slot), `list_head_addr` = 4, length stays 3, `render_en` 3 cycles after the tick.
- **Food and deferred growth.** `food_pos` = {3,8} on the first tick. Required: `food_eaten` pulse; growth is deferred until head_idx = 2; the next write lands at address 16 with `list_length` = 4.
- **Reversal and wrap.** `dir` = 2 while moving right: ignored. Head at x = 15 moving right wraps to x = 0.
- **Game over and restart.** Renderer model returns `game_over_flag` = 1. Required: `game_over` = 1, `busy` = 0, ticks ignored; `start` pulse -> INIT re-runs and `list_length` = 3.
- **Renderer stall and reset.** `render_busy` held 0 for 20 cycles: `render_en` re-pulses after 15 cycles. `rst` during RENDER_WAIT restores reset values.
